mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU's pipelined memory interface (rd/wr/addr/wrdata out; wait/rddata/rddatavalid back).
//  Holds a 16-bit-word, word-addressed RAM; accepts one request per cycle unless stalling with o_mem_wait.
//  Returns read data in order after a fixed pipeline latency; bounds outstanding reads. Sits between cpu and RAM in system top/testbench.
// PARAMETERS
//  AW         10       RAM address bits; DEPTH = 2**AW words; upper i_mem_addr bits ignored (alias)
//  READ_LAT   2        cycles from read accept edge to data-valid edge; legal 1..8
//  MAX_OUT    2        max accepted-but-unreturned reads; legal 1..READ_LAT
//  INIT_FILE  ""       if non-empty, $readmemh image loaded at elaboration
//  WAIT_SEED  16'hACE1 LFSR seed for injected stalls (WAIT_INJECT_EN only); must be nonzero
// PORTS
//  clk                i  1   clock, all state on rising edge
//  reset              i  1   asynchronous, active-low reset (0 = in reset)
//  i_mem_addr         i  16  word address; only [AW-1:0] used
//  i_mem_rd           i  1   read request
//  i_mem_wr           i  1   write request
//  i_mem_wrdata       i  16  write data
//  o_mem_wait         o  1   stall: request held by master, not accepted this cycle
//  o_mem_rddata       o  16  read data, valid only with o_mem_rddatavalid
//  o_mem_rddatavalid  o  1   one-cycle pulse per accepted read, in request order
// BEHAVIOUR
//  Reset (reset=0): o_mem_rddatavalid=0, o_mem_rddata=16'h0000, pipeline valid bits=0, outstanding count=0,
//   LFSR=WAIT_SEED; o_mem_wait=0. RAM contents NOT reset.
//  Reset mid-operation: in-flight reads discarded, never returned; writes accepted before reset persist.
//  o_mem_wait combinational: (count==MAX_OUT) | inject; inject=0 unless WAIT_INJECT_EN.
//  Accept: request sampled at edge t accepted iff (i_mem_rd|i_mem_wr) & !o_mem_wait in the cycle before t.
//  Write accept at t: RAM[addr[AW-1:0]] <= wrdata at edge t; no response generated.
//  Read accept at t: RAM read at t (sees writes accepted at t-1 or earlier); data enters READ_LAT-stage pipe;
//   o_mem_rddatavalid=1 with data in the cycle after edge t+READ_LAT-1, low next cycle unless another read due.
//  Back-to-back reads: one per cycle while count<MAX_OUT; returns back-to-back, strictly in order.
//  rd & wr same cycle (protocol violation): write performed, read dropped, count unchanged, no valid.
//  Count: +1 on read accept, -1 on valid pulse, unchanged if both same edge; never exceeds MAX_OUT, never negative.
//  Stall with count==MAX_OUT: wait deasserts combinationally in the cycle the oldest data is valid
//   (count decrements that edge), so a held read is accepted on that edge.
//  o_mem_rddata holds last returned value between pulses.
//  Address aliasing: i_mem_addr=16'h0405 with AW=10 targets word 10'h005.
// CONFIGURATION
//  MEM_RESPONDER_WAIT_INJECT_EN defined: 16-bit Galois LFSR (taps 16,14,13,11) steps every cycle out of reset;
//   inject = LFSR[1:0]==2'b00 (~25% stall cycles), OR-ed into o_mem_wait. Rules above otherwise unchanged;
//   stalls never drop, duplicate or reorder requests.
//  Not defined: inject tied 0, no LFSR flops; o_mem_wait depends only on count.
// TESTING
//  1 reset=0 for 3 cycles, release -> o_mem_wait=0, o_mem_rddatavalid=0, o_mem_rddata=0, no pulses for 10 idle cycles.
//  2 wr addr 5 data 16'h1234 at t, rd addr 5 at t+1 (READ_LAT=2) -> single valid pulse after edge t+2, rddata=16'h1234.
//  3 READ_LAT=3, MAX_OUT=2: reads addr 1,2,3 back-to-back (RAM=16'h0011,0022,0033) -> wait=1 on 3rd until 1st returns;
//     returns 0011,0022,0033 in order, exactly 3 pulses.
//  4 rd=wr=1 addr 7 data 16'hBEEF -> no valid pulse; later read addr 7 returns 16'hBEEF; rd addr 16'h0407 also BEEF.
//  5 two reads in flight, reset=0 one cycle -> no valid pulse after release, wait=0, prior written data intact.
//  6 WAIT_INJECT_EN defined: 1000 random rd/wr with held requests -> scoreboard matches all reads, wait seen 0 and 1.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU pipelined memory bus.
//   Word-addressed 16-bit RAM (DEPTH = 2**AW). Up to one request per cycle.
//   Read data comes back in request order READ_LAT cycles after accept.
//   Accepted-but-unreturned reads are limited to MAX_OUT.
// Ports:
//   clk, reset (async, active low)
//   i_mem_addr/rd/wr/wrdata  request from master, held while o_mem_wait=1
//   o_mem_wait               combinational stall
//   o_mem_rddata/valid       in-order read return, data held between pulses
// Build option: MEM_RESPONDER_WAIT_INJECT_EN adds LFSR-driven random stalls.
module mem_responder #(
  parameter int          AW        = 10,
  parameter int          READ_LAT  = 2,
  parameter int          MAX_OUT   = 2,
  parameter string       INIT_FILE = "",
  parameter logic [15:0] WAIT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic        o_mem_wait,
  output logic [15:0] o_mem_rddata,
  output logic        o_mem_rddatavalid
);
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(MAX_OUT + 1);

  logic [15:0] mem [DEPTH];

  // Upper address bits alias onto the RAM.
  logic [AW-1:0] ram_addr;
  assign ram_addr = i_mem_addr[AW-1:0];
  if (AW < 16) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_mem_addr[15:AW];
  end

  logic [READ_LAT-1:0]       vld_pipe_q, vld_pipe_d;
  logic [READ_LAT-1:0][15:0] data_pipe_q, data_pipe_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      inject, full, wr_acc, rd_acc, vld_out;

  assign vld_out = vld_pipe_q[READ_LAT-1];

  // Full releases in the cycle the oldest read returns: the count drops on
  // that same edge, so a held read can be taken without a bubble.
  assign full       = (cnt_q == CW'(MAX_OUT)) & ~vld_out;
  assign o_mem_wait = full | inject;

  // rd together with wr is treated as a write only.
  assign wr_acc = i_mem_wr & ~o_mem_wait;
  assign rd_acc = i_mem_rd & ~i_mem_wr & ~o_mem_wait;

`ifdef MEM_RESPONDER_WAIT_INJECT_EN
  // Galois LFSR, taps 16,14,13,11 (right-shift form, mask 0xB400).
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= WAIT_SEED;
    else        lfsr_q <= lfsr_d;
  end
  assign inject = (lfsr_q[1:0] == 2'b00);
`else
  localparam logic [15:0] unused_seed = WAIT_SEED;
  assign inject = 1'b0;
`endif

  // RAM is not reset; read-before-write on the same edge is naturally kept.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[ram_addr] <= i_mem_wrdata;
  end

  // Read pipe: data stages only load when a valid token moves in, so the
  // last stage keeps the previous return value between pulses.
  always_comb begin
    vld_pipe_d     = '0;
    data_pipe_d    = data_pipe_q;
    vld_pipe_d[0]  = rd_acc;
    if (rd_acc) data_pipe_d[0] = mem[ram_addr];
    for (int i = 1; i < READ_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) data_pipe_d[i] = data_pipe_q[i-1];
    end
    cnt_d = cnt_q + CW'(rd_acc) - CW'(vld_out);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
      cnt_q       <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_mem_rddatavalid = vld_out;
  assign o_mem_rddata      = data_pipe_q[READ_LAT-1];

endmodule
